// File: rtl/ternary_mul_seq_if.sv
// Operand/result bundle for the sequential balanced-ternary multiplier.
// Each trit uses 2 bits: 00=Z, 01=P, 10=N, 11=invalid.
interface ternary_mul_seq_if #(
  parameter int TRITS = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*TRITS-1:0]   a;
  logic [2*TRITS-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*TRITS-1:0]   prod_lo;
  logic [2*TRITS-1:0]   prod_hi;
  logic                 err;
  logic                 busy;

  // Requester side: supplies operands and consumes the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod_lo, prod_hi, err, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod_lo, prod_hi, err, busy
  );
endinterface

// File: rtl/ternary_mul_seq.sv
// Multi-cycle balanced-ternary shift-and-add multiplier.
// One multiplier trit is consumed per CALC cycle (LSB first). The partial
// product lives in ACC_HI:ACC_LO and is shifted right one trit per step, so
// after TRITS steps it holds the full 2*TRITS-trit product. A DONE cycle
// copies the accumulator into the output registers, applying any shift that
// an early exit skipped.
module ternary_mul_seq #(
  parameter int TRITS      = 9,
  parameter int EARLY_EXIT = 0
) (
  input logic             clk,
  input logic             rst,
  ternary_mul_seq_if.slave bus
);

  localparam int W  = 2 * TRITS;
  localparam int CW = $clog2(TRITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;        // remaining multiplier trits, current trit at [1:0]
  logic [W-1:0]    acc_hi_q;
  logic [W-1:0]    acc_lo_q;
  logic [W-1:0]    prod_hi_q;
  logic [W-1:0]    prod_lo_q;
  logic [CW-1:0]   cnt_q;      // multiplier trits consumed so far
  logic            out_valid_q;
  logic            err_q;

  logic [TRITS-1:0] a_bad;
  logic [TRITS-1:0] b_bad;
  logic             operand_bad;
  logic             accept;
  logic             calc_last;
  logic [W-1:0]     addend;
  logic [W-1:0]     sum;
  logic [1:0]       carry_t;
  logic [2*W-1:0]   final_full;

  // Trit encoding helpers.
  function automatic int tval(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] tenc(input int v);
    if (v > 0)      return 2'b01;
    else if (v < 0) return 2'b10;
    else            return 2'b00;
  endfunction

  // Per-trit invalid detection on the incoming operands and addend selection
  // from the current multiplier trit (negation swaps the P/N bits).
  genvar gi;
  generate
    for (gi = 0; gi < TRITS; gi++) begin : g_trit
      assign a_bad[gi] = &bus.a[2*gi +: 2];
      assign b_bad[gi] = &bus.b[2*gi +: 2];
      assign addend[2*gi +: 2] =
        (b_q[1:0] == 2'b01) ? a_q[2*gi +: 2] :
        (b_q[1:0] == 2'b10) ? {a_q[2*gi], a_q[2*gi+1]} :
                              2'b00;
    end
  endgenerate

  assign operand_bad = (|a_bad) || (|b_bad);
  assign accept      = (state_q == S_IDLE) && bus.in_valid;

  // Last CALC step: all trits consumed, or (early exit) the rest are Z.
  assign calc_last = (cnt_q == CW'(TRITS - 1)) ||
                     ((EARLY_EXIT != 0) && (b_q[W-1:2] == '0));

  // Exact value left to shift: the partial product is P * 3^(TRITS-cnt),
  // so a right shift by the unconsumed trit count gives the final product.
  assign final_full = {acc_hi_q, acc_lo_q} >> (2 * (TRITS - int'(cnt_q)));

  // Ripple balanced-ternary adder: ACC_HI + addend, carry-in Z.
  always_comb begin
    int c;
    int s;
    c   = 0;
    s   = 0;
    sum = '0;
    for (int i = 0; i < TRITS; i++) begin
      s = tval(acc_hi_q[2*i +: 2]) + tval(addend[2*i +: 2]) + c;
      if (s > 1) begin
        sum[2*i +: 2] = tenc(s - 3);
        c = 1;
      end else if (s < -1) begin
        sum[2*i +: 2] = tenc(s + 3);
        c = -1;
      end else begin
        sum[2*i +: 2] = tenc(s);
        c = 0;
      end
    end
    carry_t = tenc(c);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = operand_bad ? S_DONE : S_CALC;
      S_CALC: if (calc_last) state_d = S_DONE;
      S_DONE: if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand capture, shift-and-add steps, result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      prod_hi_q   <= '0;
      prod_lo_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            err_q    <= operand_bad;
          end
        end
        S_CALC: begin
          acc_lo_q <= {sum[1:0], acc_lo_q[W-1:2]};
          acc_hi_q <= {carry_t, sum[W-1:2]};
          b_q      <= {2'b00, b_q[W-1:2]};
          cnt_q    <= cnt_q + CW'(1);
        end
        S_DONE: begin
          if (!out_valid_q) begin
            prod_hi_q   <= final_full[2*W-1:W];
            prod_lo_q   <= final_full[W-1:0];
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.prod_hi   = prod_hi_q;
  assign bus.prod_lo   = prod_lo_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ternary_mul_seq.sv
// Bench for ternary_mul_seq: one DUT without and one with early exit, both
// driven by the same operand stream and checked against an integer model.
module tb_ternary_mul_seq;
  localparam int TRITS = 9;
  localparam int W     = 2 * TRITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid_d;
  logic         out_ready_d;
  logic [W-1:0] a_d;
  logic [W-1:0] b_d;

  ternary_mul_seq_if #(.TRITS(TRITS)) if0 ();
  ternary_mul_seq_if #(.TRITS(TRITS)) if1 ();

  assign if0.in_valid  = in_valid_d;
  assign if0.out_ready = out_ready_d;
  assign if0.a         = a_d;
  assign if0.b         = b_d;
  assign if1.in_valid  = in_valid_d;
  assign if1.out_ready = out_ready_d;
  assign if1.a         = a_d;
  assign if1.b         = b_d;

  ternary_mul_seq #(.TRITS(TRITS), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  ternary_mul_seq #(.TRITS(TRITS), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks   = 0;
  int failures = 0;

  logic [2*W-1:0] p0, p1;
  logic           e0, e1;
  int             lat0, lat1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Balanced-ternary encoding of an integer into n trits.
  function automatic logic [2*W-1:0] enc(input longint v, input int n);
    logic [2*W-1:0] r;
    longint x, m;
    r = '0;
    x = v;
    for (int i = 0; i < n; i++) begin
      m = x % 3;
      if (m < 0) m += 3;
      if (m == 1) begin
        r[2*i +: 2] = 2'b01;
        x = (x - 1) / 3;
      end else if (m == 2) begin
        r[2*i +: 2] = 2'b10;
        x = (x + 1) / 3;
      end else begin
        x = x / 3;
      end
    end
    return r;
  endfunction

  // Early-exit latency: significant multiplier trits k (min 1), plus one.
  function automatic int ee_latency(input longint bv);
    longint mag, lim;
    int k;
    mag = (bv < 0) ? -bv : bv;
    k   = 1;
    lim = 1;
    while (mag > lim) begin
      k++;
      lim = lim * 3 + 1;
    end
    return k + 1;
  endfunction

  task automatic wait_ready();
    for (int k = 0; k < 50 && !(if0.in_ready && if1.in_ready); k++) begin
      @(posedge clk); #1;
    end
    chk("ready_wait", {63'd0, if0.in_ready && if1.in_ready}, 64'd1);
  endtask

  // Present one operand pair for one cycle and capture each DUT's result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bit seen0, seen1;
    wait_ready();
    a_d = av;
    b_d = bv;
    in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    seen0 = 0; seen1 = 0; lat0 = -1; lat1 = -1;
    p0 = '0; p1 = '0; e0 = 1'bx; e1 = 1'bx;
    for (int cyc = 1; cyc <= 40 && !(seen0 && seen1); cyc++) begin
      @(posedge clk); #1;
      if (!seen0 && if0.out_valid) begin
        seen0 = 1; lat0 = cyc; p0 = {if0.prod_hi, if0.prod_lo}; e0 = if0.err;
      end
      if (!seen1 && if1.out_valid) begin
        seen1 = 1; lat1 = cyc; p1 = {if1.prod_hi, if1.prod_lo}; e1 = if1.err;
      end
    end
  endtask

  task automatic do_check(input string tag, input longint av, input longint bv);
    logic [2*W-1:0] ea, eb, ep;
    ea = enc(av, TRITS);
    eb = enc(bv, TRITS);
    ep = enc(av * bv, 2 * TRITS);
    run_op(ea[W-1:0], eb[W-1:0]);
    $display("op %s a=%0d b=%0d exp=%0d lat0=%0d lat1=%0d", tag, av, bv, av * bv, lat0, lat1);
    chk({tag, "_p0"},   64'(p0),   64'(ep));
    chk({tag, "_err0"}, 64'(e0),   64'd0);
    chk({tag, "_lat0"}, 64'(lat0), 64'(TRITS + 1));
    chk({tag, "_p1"},   64'(p1),   64'(ep));
    chk({tag, "_err1"}, 64'(e1),   64'd0);
    chk({tag, "_lat1"}, 64'(lat1), 64'(ee_latency(bv)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] tmp, ep;
    longint ra, rb;

    rst = 1'b1; in_valid_d = 1'b0; out_ready_d = 1'b1; a_d = '0; b_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(if0.in_ready),  64'd1);
    chk("rst_out_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_err",       64'(if0.err),       64'd0);
    chk("rst_busy",      64'(if0.busy),      64'd0);
    chk("rst_prod",      64'({if0.prod_hi, if0.prod_lo}), 64'd0);
    $display("reset checked");
    rst = 1'b0;

    do_check("basic",    5, -4);
    do_check("ext_pos",  9841, 9841);
    do_check("ext_neg", -9841, 9841);
    do_check("zero_b",   7, 0);
    do_check("one_b",    7, 1);

    // Invalid operand: low trit of a is 11.
    tmp = enc(5, TRITS);
    tmp[1:0] = 2'b11;
    ep = enc(3, TRITS);
    run_op(tmp[W-1:0], ep[W-1:0]);
    $display("op invalid a_lo=11 lat0=%0d lat1=%0d err0=%0b", lat0, lat1, e0);
    chk("inv_err0", 64'(e0),   64'd1);
    chk("inv_p0",   64'(p0),   64'd0);
    chk("inv_lat0", 64'(lat0), 64'd1);
    chk("inv_err1", 64'(e1),   64'd1);
    chk("inv_p1",   64'(p1),   64'd0);
    chk("inv_lat1", 64'(lat1), 64'd1);
    do_check("after_inv", -13, 22);

    // Backpressure: result held while out_ready=0 and new operands are offered.
    wait_ready();
    out_ready_d = 1'b0;
    tmp = enc(123, TRITS); a_d = tmp[W-1:0];
    tmp = enc(-45, TRITS); b_d = tmp[W-1:0];
    ep  = enc(123 * -45, 2 * TRITS);
    in_valid_d = 1'b1;
    @(posedge clk); #1;
    tmp = enc(77, TRITS); a_d = tmp[W-1:0];
    tmp = enc(11, TRITS); b_d = tmp[W-1:0];
    for (int k = 0; k < 30 && !if0.out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_wait", 64'(if0.out_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid0", 64'(if0.out_valid), 64'd1);
      chk("bp_prod0",  64'({if0.prod_hi, if0.prod_lo}), 64'(ep));
      chk("bp_ready0", 64'(if0.in_ready),  64'd0);
      chk("bp_prod1",  64'({if1.prod_hi, if1.prod_lo}), 64'(ep));
      chk("bp_ready1", 64'(if1.in_ready),  64'd0);
    end
    in_valid_d  = 1'b0;
    out_ready_d = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(if0.out_valid), 64'd0);
    chk("bp_release_ready", 64'(if0.in_ready),  64'd1);
    chk("bp_release_busy1", 64'(if1.busy),      64'd0);
    $display("op backpressure a=123 b=-45 held 5 cycles");
    do_check("after_bp", 31, -8);

    // Reset in the middle of CALC.
    wait_ready();
    tmp = enc(100, TRITS);  a_d = tmp[W-1:0];
    tmp = enc(-200, TRITS); b_d = tmp[W-1:0];
    in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 64'(if0.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid0", 64'(if0.out_valid), 64'd0);
    chk("mid_rst_ready0", 64'(if0.in_ready),  64'd1);
    chk("mid_rst_ready1", 64'(if1.in_ready),  64'd1);
    rst = 1'b0;
    $display("op reset mid-CALC a=100 b=-200");
    do_check("after_rst", -3, -3);

    // Randomized operands, some with short multipliers to exercise early exit.
    for (int i = 0; i < 20; i++) begin
      ra = longint'($urandom_range(19682)) - 9841;
      if (i % 3 == 0) rb = longint'($urandom_range(26)) - 13;
      else            rb = longint'($urandom_range(19682)) - 9841;
      do_check($sformatf("rnd%0d", i), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
